// File: rtl/cb_filter_pkg.sv
// Seed bundle shared by the hash-based filter blocks.
// One seed pair drives one hash row.
package cb_filter_pkg;

  typedef struct packed {
    int unsigned PermuteSeed;
    int unsigned XorSeed;
  } cb_seed_t;

endpackage

// File: rtl/sub_per_hash.sv
// Substitution/permutation hash: rotate + xor rounds, then xor-fold.
// Each round is a bit permutation plus a constant.
module sub_per_hash #(
  parameter int unsigned InpWidth   = 32'd11,
  parameter int unsigned HashWidth  = 32'd5,
  parameter int unsigned NoRounds   = 32'd1,
  parameter int unsigned PermuteKey = 32'd299034753,
  parameter int unsigned XorKey     = 32'd4094834
) (
  input  logic [InpWidth-1:0]  data_i,
  output logic [HashWidth-1:0] hash_o
);

  localparam int unsigned NoChunks =
    (InpWidth + HashWidth - 1) / HashWidth;
  localparam int unsigned PadWidth = NoChunks * HashWidth;

  function automatic logic [InpWidth-1:0] rotl(
    input logic [InpWidth-1:0] d,
    input int unsigned         sh
  );
    return (d << sh) | (d >> (InpWidth - sh));
  endfunction

  logic [InpWidth-1:0] w_mix;
  logic [PadWidth-1:0] w_pad;

  // rounds of rotate-by-seed then xor-with-seed
  always_comb begin
    w_mix = data_i;
    for (int unsigned r = 0; r < NoRounds; r++) begin
      w_mix = rotl(w_mix, (PermuteKey + r) % InpWidth)
            ^ InpWidth'(XorKey >> (r % 32));
    end
  end

  assign w_pad = PadWidth'(w_mix);

  // fold the mixed key down to a bucket index
  always_comb begin
    hash_o = '0;
    for (int unsigned c = 0; c < NoChunks; c++) begin
      hash_o ^= w_pad[c*HashWidth +: HashWidth];
    end
  end

endmodule

// File: rtl/count_min_sketch.sv
// Count-min sketch: saturating counter rows, min-of-rows estimate.
// COUNT_MIN_SKETCH_CONSERVATIVE_EN selects conservative update.
module count_min_sketch
  import cb_filter_pkg::*;
#(
  parameter int unsigned KeyWidth  = 32'd11,
  parameter int unsigned HashWidth = 32'd5,
  parameter int unsigned NoHashes  = 32'd3,
  parameter int unsigned NoRounds  = 32'd1,
  parameter int unsigned CntWidth  = 32'd4,
  parameter cb_seed_t [NoHashes-1:0] Seeds = '{
    '{PermuteSeed: 32'd299034753, XorSeed: 32'd4094834},
    '{PermuteSeed: 32'd19921030,  XorSeed: 32'd995713},
    '{PermuteSeed: 32'd294388,    XorSeed: 32'd65146511}
  }
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_valid_i,
  output logic                inc_ready_o,
  input  logic [KeyWidth-1:0] inc_key_i,
  input  logic                qry_valid_i,
  output logic                qry_ready_o,
  input  logic [KeyWidth-1:0] qry_key_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [CntWidth-1:0] rsp_cnt_o,
  input  logic                clear_i,
  output logic                busy_o,
  output logic                full_o
);

  localparam int unsigned NoBuckets = 2 ** HashWidth;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [NoHashes-1:0][NoBuckets-1:0][CntWidth-1:0] r_cnt;
  logic [HashWidth-1:0] r_clr_idx;
  logic                 r_full;
  logic                 r_rsp_valid;
  logic [CntWidth-1:0]  r_rsp_cnt;

  logic [NoHashes-1:0][HashWidth-1:0] w_inc_idx;
  logic [NoHashes-1:0][HashWidth-1:0] w_qry_idx;
  logic [NoHashes-1:0][CntWidth-1:0]  w_inc_val;
  logic [NoHashes-1:0][CntWidth-1:0]  w_qry_val;
  logic [NoHashes-1:0]                w_inc_sat;
  logic [NoHashes-1:0]                w_row_en;
  logic [CntWidth-1:0]                w_qry_min;
  logic w_inc_fire;
  logic w_qry_fire;
  logic w_clr_last;

  for (genvar g = 0; g < NoHashes; g++) begin : g_row
    sub_per_hash #(
      .InpWidth  (KeyWidth),
      .HashWidth (HashWidth),
      .NoRounds  (NoRounds),
      .PermuteKey(Seeds[g].PermuteSeed),
      .XorKey    (Seeds[g].XorSeed)
    ) u_inc_hash (
      .data_i(inc_key_i),
      .hash_o(w_inc_idx[g])
    );

    sub_per_hash #(
      .InpWidth  (KeyWidth),
      .HashWidth (HashWidth),
      .NoRounds  (NoRounds),
      .PermuteKey(Seeds[g].PermuteSeed),
      .XorKey    (Seeds[g].XorSeed)
    ) u_qry_hash (
      .data_i(qry_key_i),
      .hash_o(w_qry_idx[g])
    );

    assign w_inc_val[g] = r_cnt[g][w_inc_idx[g]];
    assign w_qry_val[g] = r_cnt[g][w_qry_idx[g]];
    assign w_inc_sat[g] = &w_inc_val[g];
  end

`ifdef COUNT_MIN_SKETCH_CONSERVATIVE_EN
  logic [CntWidth-1:0] w_inc_min;

  // smallest counter addressed by the incremented key
  always_comb begin
    w_inc_min = '1;
    for (int i = 0; i < NoHashes; i++) begin
      if (w_inc_val[i] < w_inc_min) w_inc_min = w_inc_val[i];
    end
  end

  for (genvar g = 0; g < NoHashes; g++) begin : g_en
    assign w_row_en[g] = (w_inc_val[g] == w_inc_min);
  end
`else
  assign w_row_en = '1;
`endif

  // estimate is the smallest addressed counter
  always_comb begin
    w_qry_min = '1;
    for (int i = 0; i < NoHashes; i++) begin
      if (w_qry_val[i] < w_qry_min) w_qry_min = w_qry_val[i];
    end
  end

  assign busy_o      = (r_state == CLEAR);
  assign inc_ready_o = !busy_o;
  assign qry_ready_o = !busy_o && (!r_rsp_valid || rsp_ready_i);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_cnt_o   = r_rsp_cnt;
  assign full_o      = r_full;

  // a clear request in IDLE wins over traffic that cycle
  assign w_inc_fire = inc_valid_i && inc_ready_o && !clear_i;
  assign w_qry_fire = qry_valid_i && qry_ready_o && !clear_i;
  assign w_clr_last = busy_o && (r_clr_idx == '1);

  // flush sequencing
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (clear_i) w_state_next = CLEAR;
      CLEAR:   if (w_clr_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // state and flush index registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_idx <= busy_o ? r_clr_idx + 1'b1 : '0;
    end
  end

  // counter array: flush one bucket per row or saturating increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (busy_o) begin
      for (int i = 0; i < NoHashes; i++) begin
        r_cnt[i][r_clr_idx] <= '0;
      end
    end else if (w_inc_fire) begin
      for (int i = 0; i < NoHashes; i++) begin
        if (w_row_en[i] && !w_inc_sat[i]) begin
          r_cnt[i][w_inc_idx[i]] <= w_inc_val[i] + CntWidth'(1);
        end
      end
    end
  end

  // sticky saturation flag, dropped at the end of a flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full <= 1'b0;
    end else if (w_clr_last) begin
      r_full <= 1'b0;
    end else if (w_inc_fire && |(w_row_en & w_inc_sat)) begin
      r_full <= 1'b1;
    end
  end

  // response register held until consumed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_cnt   <= '0;
    end else if (w_qry_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_cnt   <= w_qry_min;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_count_min_sketch.sv
// Directed bench for count_min_sketch (default build).
// Keys one bit apart never share a bucket in any row.
module tb_count_min_sketch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc_valid;
  logic        inc_ready;
  logic [10:0] inc_key;
  logic        qry_valid;
  logic        qry_ready;
  logic [10:0] qry_key;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_cnt;
  logic        clear;
  logic        busy;
  logic        full;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_min_sketch u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .inc_valid_i(inc_valid),
    .inc_ready_o(inc_ready),
    .inc_key_i  (inc_key),
    .qry_valid_i(qry_valid),
    .qry_ready_o(qry_ready),
    .qry_key_i  (qry_key),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_cnt_o  (rsp_cnt),
    .clear_i    (clear),
    .busy_o     (busy),
    .full_o     (full)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inc(input logic [10:0] k);
    inc_valid = 1'b1;
    inc_key   = k;
    tick();
    inc_valid = 1'b0;
  endtask

  task automatic qry(
    input string       tag,
    input logic [10:0] k,
    input int          exp
  );
    qry_valid = 1'b1;
    qry_key   = k;
    tick();
    qry_valid = 1'b0;
    chk({tag, "_vld"}, 32'(rsp_valid), 1);
    chk(tag, 32'(rsp_cnt), exp);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rsp_vld"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_cnt"}, 32'(rsp_cnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_inc_rdy"}, 32'(inc_ready), 1);
    chk({tag, "_qry_rdy"}, 32'(qry_ready), 1);
  endtask

  initial begin
    int nb;
    int rdy_bad;
    int hold_ok;
    rst_n     = 1'b0;
    inc_valid = 1'b0;
    inc_key   = '0;
    qry_valid = 1'b0;
    qry_key   = '0;
    rsp_ready = 1'b1;
    clear     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_idle("rst");

    qry("q0_a5", 11'h0A5, 0);

    repeat (3) inc(11'h0A5);
    qry("q3_a5", 11'h0A5, 3);
    qry("q_a4", 11'h0A4, 0);

    repeat (17) inc(11'h0A5);
    qry("sat_a5", 11'h0A5, 15);
    chk("full_set", 32'(full), 1);

    qry("pend", 11'h0A5, 15);
    rsp_ready = 1'b0;
    pulse_clear();
    nb      = 0;
    rdy_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) begin
        nb++;
        if (inc_ready || qry_ready) rdy_bad++;
      end
      tick();
    end
    chk("busy_cycles", 32'(nb), 32);
    chk("rdy_in_flush", 32'(rdy_bad), 0);
    chk("pend_vld", 32'(rsp_valid), 1);
    chk("pend_cnt", 32'(rsp_cnt), 15);
    rsp_ready = 1'b1;
    tick();
    chk("pend_drained", 32'(rsp_valid), 0);
    chk("full_clr", 32'(full), 0);
    qry("clr_a5", 11'h0A5, 0);
    qry("clr_a4", 11'h0A4, 0);

    repeat (2) inc(11'h001);
    inc_valid = 1'b1;
    inc_key   = 11'h001;
    qry_valid = 1'b1;
    qry_key   = 11'h001;
    tick();
    inc_valid = 1'b0;
    qry_valid = 1'b0;
    chk("same_vld", 32'(rsp_valid), 1);
    chk("same_cnt", 32'(rsp_cnt), 2);
    qry("after_same", 11'h001, 3);

    qry("hold", 11'h001, 3);
    rsp_ready = 1'b0;
    hold_ok   = 1;
    repeat (5) begin
      tick();
      if (!(rsp_valid && rsp_cnt == 4'd3 && !qry_ready))
        hold_ok = 0;
    end
    chk("hold_stable", 32'(hold_ok), 1);
    rsp_ready = 1'b1;
    tick();

    repeat (13) inc(11'h001);
    chk("full_001", 32'(full), 1);
    qry("pre_rst", 11'h001, 15);
    rsp_ready = 1'b0;
    pulse_clear();
    repeat (10) tick();
    chk("mid_flush_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("in_rst_vld", 32'(rsp_valid), 0);
    chk("in_rst_cnt", 32'(rsp_cnt), 0);
    chk("in_rst_busy", 32'(busy), 0);
    chk("in_rst_full", 32'(full), 0);
    repeat (2) tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk_idle("post_rst");
    qry("post_rst_001", 11'h001, 0);
    qry("post_rst_a5", 11'h0A5, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
